// File: rtl/poly_note_ctrl_pkg.sv
// Shared music-player definitions: voice state encoding, default sizes and
// the index-width helper used by the voice controller and its arbiter.
package poly_note_ctrl_pkg;

    localparam int DEF_VOICES = 4;
    localparam int DEF_DUR_W  = 6;
    localparam int STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_LOAD = 3'd3,
        ST_PLAY = 3'd4,
        ST_DONE = 3'd5
    } voice_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/poly_note_ctrl_rr_arbiter.sv
// Round-robin arbiter with a held grant: a winner that is not yet accepted
// keeps the grant while it is still requesting.
module rr_arbiter
    import poly_note_ctrl_pkg::*;
#(
    parameter int N = DEF_VOICES,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] ptr;
    logic [W-1:0] held_idx;
    logic         held;

    always_comb begin : pick
        int cand;
        cand      = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (held && req[held_idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = held_idx;
        end else begin
            for (int i = 0; i < N; i++) begin
                cand = int'(ptr) + i;
                if (cand >= N) cand = cand - N;
                if (!gnt_valid && req[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = W'(cand);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            held     <= 1'b0;
            held_idx <= '0;
        end else begin
            held     <= gnt_valid & ~accept;
            held_idx <= gnt_idx;
            if (gnt_valid && accept)
                ptr <= (gnt_idx == W'(N-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/poly_note_ctrl.sv
// Polyphonic note controller: one request/wait/load/play FSM per voice,
// sharing a single song-reader request port through a round-robin arbiter.
module poly_note_ctrl
    import poly_note_ctrl_pkg::*;
#(
    parameter int VOICES = DEF_VOICES,
    parameter int DUR_W  = DEF_DUR_W,
    localparam int VW = idx_width(VOICES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        play_enable,
    input  logic                        pause,
    input  logic                        beat,
    output logic                        req_valid,
    output logic [VW-1:0]               req_voice,
    input  logic                        req_ready,
    input  logic                        new_note_valid,
    input  logic [VW-1:0]               new_note_voice,
    input  logic [DUR_W-1:0]            new_note_dur,
    output logic [VOICES-1:0]           load,
    output logic [VOICES-1:0]           note_done,
    output logic [VOICES-1:0]           voice_active,
    output logic [VOICES*STATE_W-1:0]   voice_state
);

    // Handshake: a request transfers in any cycle where req_valid and
    // req_ready are both high; until then req_valid/req_voice stay put.
    voice_state_t        state      [VOICES];
    voice_state_t        state_next [VOICES];
    logic [DUR_W-1:0]    cnt        [VOICES];
    logic [VOICES-1:0]   in_req;
    logic                gnt_valid;
    logic [VW-1:0]       gnt_idx;
    logic                accept;

    assign accept    = gnt_valid & req_ready;
    assign req_valid = gnt_valid;
    assign req_voice = gnt_idx;

    rr_arbiter #(.N(VOICES)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (in_req),
        .accept    (accept),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge clk) begin
        for (int v = 0; v < VOICES; v++) begin
            if (reset) begin
                state[v] <= ST_IDLE;
                cnt[v]   <= '0;
            end else begin
                state[v] <= state_next[v];
                if (state[v] == ST_WAIT && new_note_valid && new_note_voice == VW'(v))
                    cnt[v] <= new_note_dur;
                else if (state[v] == ST_PLAY && beat && !pause)
                    cnt[v] <= cnt[v] - 1'b1;
            end
        end
    end

    always_comb begin
        for (int v = 0; v < VOICES; v++) begin
            state_next[v] = state[v];
            if (!play_enable) begin
                state_next[v] = ST_IDLE;
            end else begin
                case (state[v])
                    ST_IDLE: state_next[v] = ST_REQ;
                    ST_REQ:  if (accept && gnt_idx == VW'(v)) state_next[v] = ST_WAIT;
                    ST_WAIT: if (new_note_valid && new_note_voice == VW'(v)) state_next[v] = ST_LOAD;
                    ST_LOAD: state_next[v] = (cnt[v] == '0) ? ST_DONE : ST_PLAY;
                    // Ending on the 1->0 beat makes PLAY last exactly D counted beats.
                    ST_PLAY: if (beat && !pause && cnt[v] == DUR_W'(1)) state_next[v] = ST_DONE;
                    ST_DONE: state_next[v] = ST_REQ;
                    default: state_next[v] = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        in_req       = '0;
        load         = '0;
        note_done    = '0;
        voice_active = '0;
        voice_state  = '0;
        for (int v = 0; v < VOICES; v++) begin
            in_req[v]       = (state[v] == ST_REQ);
            load[v]         = (state[v] == ST_LOAD);
            note_done[v]    = (state[v] == ST_DONE);
            voice_active[v] = (state[v] == ST_PLAY);
            voice_state[v*STATE_W +: STATE_W] = state[v];
        end
    end

endmodule

// File: tb/tb_poly_note_ctrl.sv
// Bench for poly_note_ctrl: directed scenarios then random traffic, all
// checked cycle by cycle against a flag-based behavioural voice model.
module tb_poly_note_ctrl;

    localparam int V  = 4;
    localparam int DW = 6;
    localparam int VW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            play_enable;
    logic            pause;
    logic            beat;
    logic            req_valid;
    logic [VW-1:0]   req_voice;
    logic            req_ready;
    logic            new_note_valid;
    logic [VW-1:0]   new_note_voice;
    logic [DW-1:0]   new_note_dur;
    logic [V-1:0]    load;
    logic [V-1:0]    note_done;
    logic [V-1:0]    voice_active;
    logic [V*3-1:0]  voice_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: each voice is described by what it is doing.
    bit m_idle [V];
    bit m_want [V];
    bit m_wait [V];
    bit m_load [V];
    bit m_play [V];
    bit m_done [V];
    int m_left [V];
    int m_ptr;
    int m_hold;
    bit m_after_rst;

    poly_note_ctrl #(.VOICES(V), .DUR_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .play_enable    (play_enable),
        .pause          (pause),
        .beat           (beat),
        .req_valid      (req_valid),
        .req_voice      (req_voice),
        .req_ready      (req_ready),
        .new_note_valid (new_note_valid),
        .new_note_voice (new_note_voice),
        .new_note_dur   (new_note_dur),
        .load           (load),
        .note_done      (note_done),
        .voice_active   (voice_active),
        .voice_state    (voice_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < V; v++) begin
            m_idle[v] = 1; m_want[v] = 0; m_wait[v] = 0;
            m_load[v] = 0; m_play[v] = 0; m_done[v] = 0; m_left[v] = 0;
        end
        m_ptr  = 0;
        m_hold = -1;
        m_after_rst = 1;
    endtask

    function automatic int exp_grant();
        if (m_hold >= 0 && m_want[m_hold]) return m_hold;
        for (int i = 0; i < V; i++) begin
            if (m_want[(m_ptr + i) % V]) return (m_ptr + i) % V;
        end
        return -1;
    endfunction

    task automatic compare();
        int g;
        logic [V-1:0] el, ed, ea;
        g = exp_grant();
        for (int v = 0; v < V; v++) begin
            el[v] = m_load[v];
            ed[v] = m_done[v];
            ea[v] = m_play[v];
        end
        check("req_valid", req_valid, (g >= 0) ? 1 : 0);
        if (g >= 0 || m_after_rst) check("req_voice", req_voice, (g >= 0) ? g : 0);
        check("load", load, el);
        check("note_done", note_done, ed);
        check("voice_active", voice_active, ea);
    endtask

    task automatic model_update(input bit rst, input bit pe, input bit ps, input bit bt,
                                input bit rr, input bit nv, input int nvoice, input int ndur);
        int g;
        bit acc;
        if (rst) begin
            model_reset();
            return;
        end
        m_after_rst = 0;
        g   = exp_grant();
        acc = (g >= 0) && rr;
        m_hold = (g >= 0 && !rr) ? g : -1;
        if (acc) m_ptr = (g + 1) % V;
        for (int v = 0; v < V; v++) begin
            if (!pe) begin
                m_idle[v] = 1; m_want[v] = 0; m_wait[v] = 0;
                m_load[v] = 0; m_play[v] = 0; m_done[v] = 0;
            end else if (m_idle[v]) begin
                m_idle[v] = 0; m_want[v] = 1;
            end else if (m_want[v]) begin
                if (acc && g == v) begin m_want[v] = 0; m_wait[v] = 1; end
            end else if (m_wait[v]) begin
                if (nv && nvoice == v) begin m_wait[v] = 0; m_load[v] = 1; m_left[v] = ndur; end
            end else if (m_load[v]) begin
                m_load[v] = 0;
                if (m_left[v] == 0) m_done[v] = 1; else m_play[v] = 1;
            end else if (m_play[v]) begin
                if (bt && !ps) begin
                    m_left[v]--;
                    if (m_left[v] == 0) begin m_play[v] = 0; m_done[v] = 1; end
                end
            end else if (m_done[v]) begin
                m_done[v] = 0; m_want[v] = 1;
            end
        end
    endtask

    // One cycle: check current outputs, drive next inputs, advance the model.
    task automatic step(input bit rst, input bit pe, input bit ps, input bit bt,
                        input bit rr, input bit nv, input int nvoice, input int ndur);
        compare();
        reset          = rst;
        play_enable    = pe;
        pause          = ps;
        beat           = bt;
        req_ready      = rr;
        new_note_valid = nv;
        new_note_voice = VW'(nvoice);
        new_note_dur   = DW'(ndur);
        model_update(rst, pe, ps, bt, rr, nv, nvoice, ndur);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        reset = 1; play_enable = 0; pause = 0; beat = 0; req_ready = 0;
        new_note_valid = 0; new_note_voice = '0; new_note_dur = '0;
        repeat (2) @(negedge clk);
        model_reset();

        // Reset, then all voices request and are granted 0,1,2,3 in turn.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 1, 0, 0, 0);

        // Voice 2 plays a 3-beat note.
        step(0, 1, 0, 0, 1, 1, 2, 3);
        for (int i = 0; i < 10; i++) step(0, 1, 0, i % 2, 1, 0, 0, 0);

        // Zero-length note on voice 0.
        step(0, 1, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0, 0, 0);

        // Voice 1 plays 5 beats with 4 paused beats and a stray delivery.
        step(0, 1, 0, 0, 1, 1, 1, 5);
        step(0, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1, i % 2, 1, (i == 3), 1, 2);
        for (int i = 0; i < 14; i++) step(0, 1, 0, i % 2, 1, 0, 0, 0);

        // Requests stalled by req_ready low, then released.
        step(0, 1, 0, 0, 0, 1, 3, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 0, 0, 0);

        // play_enable drop, then reset in the middle of a stalled handshake.
        step(0, 1, 0, 0, 1, 1, 0, 4);
        step(0, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 59) != 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, V - 1)),
                 int'($urandom_range(0, 5)));
        end
        compare();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/poly_note_ctrl.md
POLY_NOTE_CTRL -- requirements
Module: poly_note_ctrl

Interface
REQ-001 Parameter VOICES, default 4, number of independent note voices (2..8).
REQ-002 Parameter DUR_W, default 6, width of note duration in beat ticks.
REQ-003 Derived constant VW = max(1, clog2(VOICES)), width of voice index.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 play_enable  in  1  level; high = voices run, low = all voices forced idle.
REQ-007 pause  in  1  level; high freezes all duration counters.
REQ-008 beat  in  1  one-cycle tick strobe; advances note durations.
REQ-009 req_valid  out  1  request to song reader for the next note of voice req_voice.
REQ-010 req_voice  out  VW  voice index of current request.
REQ-011 req_ready  in  1  song reader accepts request this cycle.
REQ-012 new_note_valid  in  1  note delivery strobe from song reader.
REQ-013 new_note_voice  in  VW  target voice of delivered note.
REQ-014 new_note_dur  in  DUR_W  delivered note duration in beats.
REQ-015 load  out  VOICES  one-hot per voice; one-cycle pulse latching the new note into that voice's synthesiser.
REQ-016 note_done  out  VOICES  per-voice one-cycle pulse at end of note.
REQ-017 voice_active  out  VOICES  per-voice level, high while that voice is in PLAY.

Function
REQ-018 Each voice SHALL run an independent FSM: IDLE, REQ, WAIT, LOAD, PLAY, DONE; outputs decoded combinationally from state.
REQ-019 IDLE -> REQ when play_enable high; otherwise stay.
REQ-020 REQ: voice is a request candidate; -> WAIT in the cycle it is granted (req_valid & req_ready & req_voice == v).
REQ-021 WAIT -> LOAD when new_note_valid & new_note_voice == v; voice latches new_note_dur into its DUR_W counter.
REQ-022 LOAD: load[v]=1 for exactly one cycle; -> PLAY, or -> DONE if latched duration is 0.
REQ-023 PLAY: counter decrements on beat & ~pause; on the beat that takes the counter from 1 to 0 -> DONE, so PLAY spans exactly D counted beats.
REQ-024 DONE: note_done[v]=1 for exactly one cycle; -> REQ.
REQ-025 play_enable low in any state SHALL force that voice to IDLE on the next edge; the current-cycle decoded output (e.g. load pulse) still appears once.
REQ-026 pause SHALL NOT block request, grant, or load; only counting stops.
REQ-027 Arbiter: round-robin among voices in REQ; priority starts at voice 0 after reset and moves to granted voice + 1 (mod VOICES) on each accepted request.
REQ-028 req_valid and req_voice SHALL be held stable while req_valid & ~req_ready; re-arbitration only after acceptance or if the requesting voice leaves REQ (play_enable low).
REQ-029 new_note_valid for a voice not in WAIT SHALL be ignored with no state change.
REQ-030 Multiple voices may occupy LOAD, PLAY, DONE simultaneously; load and note_done may have several bits set in one cycle.
REQ-031 Latency: delivery in cycle t -> load pulse in cycle t+1; final beat in cycle t -> note_done in cycle t+1.

Reset
REQ-032 reset SHALL put every voice in IDLE, clear all counters, set arbiter pointer to 0; load, note_done, voice_active, req_valid = 0 and req_voice = 0 from the following cycle.
REQ-033 reset SHALL take precedence over all other inputs, including mid-note and mid-handshake.

Structure
REQ-034 State encodings and default VOICES/DUR_W SHALL live in the shared music-player package.
REQ-035 Round-robin arbitration SHALL be a separate sub-module rr_arbiter (parameter N), instantiated once.

Verification
REQ-036 VOICES=4: reset, play_enable=1, req_ready=1 -> grants to voices 0,1,2,3 on consecutive cycles; all req_valid low afterwards.
REQ-037 Voice 2 in WAIT, deliver dur=3 -> load[2] next cycle; voice_active[2] high for exactly 3 beats; note_done[2] one cycle after third beat; voice 2 re-requests.
REQ-038 req_ready held low 5 cycles with voices 1 and 3 in REQ -> req_voice stays 1 all 5 cycles; after accept, voice 3 granted next.
REQ-039 dur=0 delivered to voice 0 -> load[0] then note_done[0] on consecutive cycles, voice_active[0] never high.
REQ-040 pause high for 4 beats mid-note (dur=5) -> note ends after 5 unpaused beats; delivery to a PLAY voice ignored.
REQ-041 play_enable dropped mid-PLAY, then reset mid-handshake -> all voices IDLE next cycle, all outputs 0, arbiter restarts at voice 0.
